// File: rtl/rop_dcr_bank.sv
// Purpose : multi-context ROP DCR store; writes land in a shadow file, commits copy it into one of
//           NUM_SETS active sets once every in-flight tile tagged with that set has retired.
// Latency : commit accept -> commit_done >= 2 cycles (DRAIN then COPY); read data 1 cycle after rd_valid.
// Backpr. : commit_ready low outside IDLE; use_inc_ready low for the set being committed or at a
//           saturated counter; DCR writes and tile retires are always accepted.
// Ports   : clk/reset_n (async active-low); dcr_wr_* DCR bus write; commit_* commit handshake and
//           done pulse; use_inc_* / use_dec_* tile entry/exit tagging; rd_* set readout, word i of
//           the set at rd_data[i*32 +: 32].
module rop_dcr_bank #(
   parameter int          NUM_SETS      = 2,
   parameter int          NUM_REGS      = 12,
   parameter logic [11:0] DCR_BASE      = 12'h020,
   parameter int          CNT_BITS      = 8,
   parameter bit          UNDERFLOW_CHK = 1'b1,
   localparam int         SET_BITS      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     dcr_wr_valid,
   input  logic [11:0]              dcr_wr_addr,
   input  logic [31:0]              dcr_wr_data,
   input  logic                     commit_valid,
   input  logic [SET_BITS-1:0]      commit_set,
   output logic                     commit_ready,
   output logic                     commit_done,
   input  logic                     use_inc_valid,
   input  logic [SET_BITS-1:0]      use_inc_set,
   output logic                     use_inc_ready,
   input  logic                     use_dec_valid,
   input  logic [SET_BITS-1:0]      use_dec_set,
   input  logic                     rd_valid,
   input  logic [SET_BITS-1:0]      rd_set,
   output logic                     rd_data_valid,
   output logic [NUM_REGS*32-1:0]   rd_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_COPY  = 2'd2;

   typedef logic [31:0]         word_t;
   typedef logic [CNT_BITS-1:0] cnt_t;

   word_t                 shadow_q [NUM_REGS];
   word_t                 shadow_d [NUM_REGS];
   word_t                 active_q [NUM_SETS][NUM_REGS];
   word_t                 active_d [NUM_SETS][NUM_REGS];
   cnt_t                  cnt_q    [NUM_SETS];
   cnt_t                  cnt_d    [NUM_SETS];
   logic [1:0]            state_q, state_d;
   logic [SET_BITS-1:0]   pend_set_q, pend_set_d;
   logic                  rd_data_valid_q, rd_data_valid_d;
   logic [NUM_REGS*32-1:0] rd_data_q, rd_data_d;

   logic [NUM_SETS-1:0]   inc_fire;
   logic [NUM_SETS-1:0]   dec_fire;
   logic                  inc_blocked;
   logic                  inc_sat;
   logic                  pend_zero;
   logic                  dec_underflow;

   // Word 2 (cbuf_mask) comes out of reset as all-ones so colour writes are enabled by default.
   function automatic word_t reset_word(input int i);
      return (i == 2) ? 32'hFFFF_FFFF : 32'h0000_0000;
   endfunction

   assign commit_ready  = (state_q == ST_IDLE);
   assign commit_done   = (state_q == ST_COPY);
   assign rd_data_valid = rd_data_valid_q;
   assign rd_data       = rd_data_q;

   always_comb begin
      // Shadow capture; addresses outside the window simply never match.
      shadow_d = shadow_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (dcr_wr_valid && (dcr_wr_addr == DCR_BASE + 12'(i))) shadow_d[i] = dcr_wr_data;
      end

      // Entry is held only for the set awaiting a commit, and at counter saturation.
      inc_blocked = (state_q != ST_IDLE) && (use_inc_set == pend_set_q);
      inc_sat     = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
         if ((use_inc_set == SET_BITS'(s)) && (cnt_q[s] == '1)) inc_sat = 1'b1;
      end
      use_inc_ready = !inc_blocked && !inc_sat;

      cnt_d         = cnt_q;
      inc_fire      = '0;
      dec_fire      = '0;
      dec_underflow = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
         inc_fire[s] = use_inc_valid && use_inc_ready && (use_inc_set == SET_BITS'(s));
         dec_fire[s] = use_dec_valid && (use_dec_set == SET_BITS'(s)) && (cnt_q[s] != '0);
         if (use_dec_valid && (use_dec_set == SET_BITS'(s)) && (cnt_q[s] == '0)) dec_underflow = 1'b1;
         if (inc_fire[s] && !dec_fire[s]) cnt_d[s] = cnt_q[s] + cnt_t'(1);
         if (dec_fire[s] && !inc_fire[s]) cnt_d[s] = cnt_q[s] - cnt_t'(1);
      end

      // Drain completes on the post-update count so a retire in the last DRAIN cycle counts.
      // A pending set id with no backing set never matches and drains immediately.
      pend_zero = 1'b1;
      for (int s = 0; s < NUM_SETS; s++) begin
         if ((pend_set_q == SET_BITS'(s)) && (cnt_d[s] != '0)) pend_zero = 1'b0;
      end

      state_d    = state_q;
      pend_set_d = pend_set_q;
      case (state_q)
         ST_IDLE: begin
            if (commit_valid) begin
               state_d    = ST_DRAIN;
               pend_set_d = commit_set;
            end
         end
         ST_DRAIN: if (pend_zero) state_d = ST_COPY;
         ST_COPY:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Copy takes shadow_d so a DCR write landing in the COPY cycle is included.
      active_d = active_q;
      if (state_q == ST_COPY) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            if (pend_set_q == SET_BITS'(s)) active_d[s] = shadow_d;
         end
      end

      // Reads sample active_q, so a same-cycle COPY is not visible to them.
      rd_data_valid_d = rd_valid;
      rd_data_d       = rd_data_q;
      if (rd_valid) begin
         rd_data_d = '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            if (rd_set == SET_BITS'(s)) begin
               for (int i = 0; i < NUM_REGS; i++) rd_data_d[i*32 +: 32] = active_q[s][i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= reset_word(i);
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int i = 0; i < NUM_REGS; i++) active_q[s][i] <= reset_word(i);
            cnt_q[s] <= '0;
         end
         state_q         <= ST_IDLE;
         pend_set_q      <= '0;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= '0;
      end else begin
         shadow_q        <= shadow_d;
         active_q        <= active_d;
         cnt_q           <= cnt_d;
         state_q         <= state_d;
         pend_set_q      <= pend_set_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_q       <= rd_data_d;
      end
   end

   // A retire with no matching entry points at a tagging bug upstream; the count is left at zero.
   always_ff @(posedge clk) begin
      if (UNDERFLOW_CHK && reset_n) begin
         assert (!dec_underflow) else $error("rop_dcr_bank: use_dec on a set with no in-flight tiles");
      end
   end

endmodule
